// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: freeze/flush generation, RAW hazard detection,
// multi-cycle SRAM wait FSM, and saturating stall counter. Optional macro: FORWARD_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             exe_branch,
  input  logic             mem_rd_req,
  input  logic             mem_wr_req,
  input  logic             sram_ready,
  input  logic             cnt_clr,
  output logic             freeze_if,
  output logic             flush_if_id,
  output logic             freeze_id_ex,
  output logic             flush_id_ex,
  output logic             freeze_ex_mem,
  output logic             bubble_mem_wb,
  output logic             sram_start,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT);

  typedef enum logic {
    IDLE,
    MEM_WAIT
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_mem_err;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic                w_req;
  logic                w_launch;
  logic                w_mem_stall;
  logic                w_timeout;
  logic                w_ex_match;
  logic                w_mem_match;
  logic                w_hazard;
  logic                w_unused;

  assign w_req = mem_rd_req | mem_wr_req;

  assign w_ex_match  = (id_use_src1 && exe_wb_en && (id_src1 == exe_dest)) ||
                       (id_use_src2 && exe_wb_en && (id_src2 == exe_dest));
  assign w_mem_match = (id_use_src1 && mem_wb_en && (id_src1 == mem_dest)) ||
                       (id_use_src2 && mem_wb_en && (id_src2 == mem_dest));

`ifdef FORWARD_EN
  // ALU results are forwarded; only a load in EX cannot be bypassed in time.
  assign w_hazard = w_ex_match && exe_mem_r;
  assign w_unused = w_mem_match;
`else
  assign w_hazard = w_ex_match || w_mem_match;
  assign w_unused = exe_mem_r;
`endif

  // Launch is gated by rst so no access starts while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_mem_stall = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req && !rst) begin
          w_launch    = 1'b1;
          w_mem_stall = 1'b1;
          w_state_nxt = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (sram_ready) begin
          w_state_nxt = IDLE;
        end else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_mem_stall = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    freeze_if     = 1'b0;
    flush_if_id   = 1'b0;
    freeze_id_ex  = 1'b0;
    flush_id_ex   = 1'b0;
    freeze_ex_mem = 1'b0;
    bubble_mem_wb = 1'b0;
    if (w_mem_stall) begin
      freeze_if     = 1'b1;
      freeze_id_ex  = 1'b1;
      freeze_ex_mem = 1'b1;
      bubble_mem_wb = 1'b1;
    end else if (exe_branch) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (w_hazard) begin
      freeze_if   = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wait      <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == MEM_WAIT) && w_mem_stall) begin
        r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end
      if (w_timeout) begin
        r_mem_err <= 1'b1;
      end
      if (cnt_clr) begin
        r_stall_cnt <= '0;
      end else if ((w_mem_stall || w_hazard) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign sram_start = w_launch;
  assign mem_err    = r_mem_err;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage ARM-subset core. It generates the freeze and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects RAW hazards between the ID-stage sources and the EXE/MEM destinations, and squashes wrong-path instructions on a taken branch. It also runs a multi-cycle SRAM access state machine that stalls the whole pipeline until memory completes, and it keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- TIMEOUT, 64, maximum MEM_WAIT cycles before the access is abandoned (must be ≥2).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_src1  in  4  Rn index of the instruction in ID.
- id_src2  in  4  Rm/Rd-store index of the instruction in ID.
- id_use_src1  in  1  ID instruction reads id_src1.
- id_use_src2  in  1  ID instruction reads id_src2.
- exe_dest  in  4  destination index in EX.
- exe_wb_en  in  1  EX instruction writes back.
- exe_mem_r  in  1  EX instruction is a load.
- mem_dest  in  4  destination index in MEM.
- mem_wb_en  in  1  MEM instruction writes back.
- exe_branch  in  1  EX instruction is a taken branch.
- mem_rd_req  in  1  MEM instruction is a load.
- mem_wr_req  in  1  MEM instruction is a store.
- sram_ready  in  1  SRAM access complete (sampled only in MEM_WAIT).
- cnt_clr  in  1  synchronous clear of stall_cnt.
- freeze_if  out  1  hold PC and IF/ID.
- flush_if_id  out  1  zero IF/ID.
- freeze_id_ex  out  1  hold ID/EX.
- flush_id_ex  out  1  zero ID/EX (bubble).
- freeze_ex_mem  out  1  hold EX/MEM.
- bubble_mem_wb  out  1  load MEM/WB with zeros.
- sram_start  out  1  one-cycle SRAM access launch.
- mem_err  out  1  sticky timeout flag.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

## Operation
- FSM states: IDLE, MEM_WAIT.
  - IDLE → MEM_WAIT when mem_rd_req|mem_wr_req. In that same cycle: sram_start=1 and mem_stall=1.
  - MEM_WAIT, sram_ready=0: mem_stall=1; the wait counter increments.
  - MEM_WAIT, sram_ready=1: mem_stall=0; → IDLE; the pipeline advances this cycle.
  - MEM_WAIT, wait counter reaches TIMEOUT-1 with no ready: mem_err←1 (sticky until rst); mem_stall=0; → IDLE.
- mem_stall=1 forces freeze_if=freeze_id_ex=freeze_ex_mem=bubble_mem_wb=1 and flush_if_id=flush_id_ex=0. This has top priority, so branch and hazard are deferred; their inputs remain valid because the stages are held.
- Branch (mem_stall=0, exe_branch=1): flush_if_id=1 and flush_id_ex=1. Hazards are ignored in this cycle; freeze_if=0.
- Hazard (mem_stall=0, exe_branch=0, hazard=1): freeze_if=1 and flush_id_ex=1. All other outputs are 0.
- A match is use_srcN && wb_en && srcN==dest, evaluated for N=1,2 against the EX and MEM destinations.
- stall_cnt increments on every cycle with mem_stall|hazard. It saturates at all-ones. cnt_clr has priority over increment.
- A new request in the cycle right after the return to IDLE launches a new access normally.

## Timing
- Freeze, flush, bubble and sram_start outputs are combinational from inputs and state, so they take effect at the next edge.
- Minimum memory stall is 1 cycle: the IDLE launch cycle plus a MEM_WAIT cycle in which ready arrives. Ready on the first MEM_WAIT cycle gives a 1-cycle stall.
- Reset values: state=IDLE, wait counter=0, mem_err=0, stall_cnt=0. While rst=1, sram_start=0.
- rst asserted mid-MEM_WAIT aborts the access immediately. No sram_start follows until rst deasserts.

## Configuration
- FORWARD_EN defined: the forwarding unit covers ALU results. hazard = EX match && exe_mem_r (load-use only); MEM-stage matches are ignored.
- FORWARD_EN undefined: hazard = any EX match or any MEM match, regardless of exe_mem_r.

## Test plan
- ID src1=3 (use=1), EX dest=3, wb_en=1, mem_r=0 → without FORWARD_EN: freeze_if=1, flush_id_ex=1, stall_cnt 0→1. With FORWARD_EN: all outputs 0.
- Same case with exe_mem_r=1 and FORWARD_EN → exactly 1 stall cycle, then no stall once the load moves to MEM.
- mem_rd_req=1, sram_ready arrives after 4 MEM_WAIT cycles → sram_start=1 for 1 cycle; all freezes and bubble_mem_wb=1 for 5 cycles; release on the ready cycle; stall_cnt=5.
- exe_branch=1 together with a hazard condition → flush_if_id=1, flush_id_ex=1, freeze_if=0.
- exe_branch=1 during MEM_WAIT → only the freezes are asserted. Flushes fire in the cycle sram_ready=1.
- TIMEOUT=8, sram_ready held 0 → release after 8 MEM_WAIT cycles, mem_err=1. rst mid-wait → mem_err=0, state IDLE, stall_cnt=0.
